// File: rtl/dll_walker.sv
// rtl/dll_walker.sv - MARIA display-list-list walker feeding the line-fetch stage
//
// Walks the DLL starting at ZP, fetching 3-byte entries over a req/ack port,
// and for each visible line emits the zone's display-list pointer, the line
// offset within the zone (counting down), the holey-DMA bits and a DLI pulse.
//
// Ports
//   sysclock     system clock, rising edge
//   reset_b      asynchronous active-low reset
//   ZP           DLL base address, loaded on frame_start
//   dma_en       DMA enabled
//   frame_start  pulse at the first DMA line of a frame
//   line_start   pulse at the start of each line's DMA window
//   mem_req      read request (registered)
//   mem_addr     read address, stable while mem_req is high
//   mem_ack      access complete
//   mem_data     read data, valid with mem_ack
//   dl_valid     pulse: dl_ptr/dl_offset/holey valid for this line
//   dl_ptr       display-list address of the current zone
//   dl_offset    line offset within the zone
//   holey        {H16,H8}
//   dli          pulse when the fetched entry requests a DLI
//   late         pulse when line_start arrives while busy (line dropped)
//   busy         walker not idle
module dll_walker #(
   parameter int ENTRY_BYTES = 3
) (
   input  logic        sysclock,
   input  logic        reset_b,
   input  logic [15:0] ZP,
   input  logic        dma_en,
   input  logic        frame_start,
   input  logic        line_start,
   output logic        mem_req,
   output logic [15:0] mem_addr,
   input  logic        mem_ack,
   input  logic [7:0]  mem_data,
   output logic        dl_valid,
   output logic [15:0] dl_ptr,
   output logic [3:0]  dl_offset,
   output logic [1:0]  holey,
   output logic        dli,
   output logic        late,
   output logic        busy
);

   // Fetch states are numbered so that the last entry byte lands in state ENTRY_BYTES.
   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_F0   = 3'd1,
      S_F1   = 3'd2,
      S_F2   = 3'd3,
      S_EMIT = 3'd4
   } state_t;

   state_t      r_state;
   state_t      w_next;

   logic [15:0] r_dll_addr;
   logic [3:0]  r_zone_cnt;
   logic        r_need_fetch;
   logic [2:0]  r_b0_flags;     // {DLI,H16,H8}
   logic [3:0]  r_b0_off;
   logic [7:0]  r_byte1;
   logic [15:0] r_dl_ptr;
   logic [3:0]  r_dl_offset;
   logic [1:0]  r_holey;
   logic        r_dli;
   logic        r_mem_req;
   logic        r_abort;        // frame_start seen mid-fetch; finish the access then reload
   logic [15:0] r_zp_lat;
   logic        r_emit_hold;    // non-fetch lines spend one cycle in EMIT before the pulse

   logic        w_fetching;
   logic        w_last_fetch;
   logic        w_abort;
   logic        w_line;
   logic        w_frame_load;
   logic        w_go_fetch;
   logic        w_go_emit;
   logic        w_unused_rsvd;

   assign w_fetching   = (r_state == S_F0) || (r_state == S_F1) || (r_state == S_F2);
   assign w_last_fetch = (r_state == state_t'(3'(ENTRY_BYTES)));
   assign w_abort      = r_abort || frame_start;
   assign w_line       = (r_state == S_IDLE) && line_start && dma_en;
   assign w_frame_load = (r_state == S_IDLE) && frame_start && dma_en;
   // A frame load in the same cycle as a line forces that line to fetch from ZP.
   assign w_go_fetch   = w_line && (r_need_fetch || w_frame_load);
   assign w_go_emit    = w_line && !w_go_fetch;
   // Byte0 bit 4 is reserved in the entry format.
   assign w_unused_rsvd = mem_data[4];

   always_ff @(posedge sysclock or negedge reset_b) begin
      if (!reset_b) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE: begin
            if (w_go_fetch) begin
               w_next = S_F0;
            end else if (w_go_emit) begin
               w_next = S_EMIT;
            end
         end
         S_F0:    if (mem_ack) w_next = w_abort ? S_IDLE : S_F1;
         S_F1:    if (mem_ack) w_next = w_abort ? S_IDLE : S_F2;
         S_F2:    if (mem_ack) w_next = w_abort ? S_IDLE : S_EMIT;
         S_EMIT:  if (!r_emit_hold) w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge sysclock or negedge reset_b) begin
      if (!reset_b) begin
         r_dll_addr   <= 16'h0000;
         r_zone_cnt   <= 4'h0;
         r_need_fetch <= 1'b1;
         r_b0_flags   <= 3'b000;
         r_b0_off     <= 4'h0;
         r_byte1      <= 8'h00;
         r_dl_ptr     <= 16'h0000;
         r_dl_offset  <= 4'h0;
         r_holey      <= 2'b00;
         r_dli        <= 1'b0;
         r_mem_req    <= 1'b0;
         r_abort      <= 1'b0;
         r_zp_lat     <= 16'h0000;
         r_emit_hold  <= 1'b0;
      end else begin
         r_mem_req <= (w_next == S_F0) || (w_next == S_F1) || (w_next == S_F2);
         r_dli     <= 1'b0;

         if (w_go_emit) begin
            r_zone_cnt  <= r_zone_cnt - 4'd1;
            r_emit_hold <= 1'b1;
         end

         if (w_fetching) begin
            if (frame_start && !r_abort) begin
               r_abort  <= 1'b1;
               r_zp_lat <= ZP;
            end
            if (mem_ack) begin
               if (w_abort) begin
                  // Data of the abandoned access is dropped; the newest ZP wins.
                  r_dll_addr   <= frame_start ? ZP : r_zp_lat;
                  r_need_fetch <= 1'b1;
                  r_abort      <= 1'b0;
               end else begin
                  r_dll_addr <= r_dll_addr + 16'd1;
                  if (r_state == S_F0) begin
                     r_b0_flags <= mem_data[7:5];
                     r_b0_off   <= mem_data[3:0];
                  end else if (r_state == S_F1) begin
                     r_byte1 <= mem_data;
                  end else if (w_last_fetch) begin
                     r_zone_cnt  <= r_b0_off;
                     r_dl_offset <= r_b0_off;
                     r_dl_ptr    <= {r_byte1, mem_data};
                     r_holey     <= r_b0_flags[1:0];
                     r_dli       <= r_b0_flags[2];
                  end
               end
            end
         end

         if (r_state == S_EMIT) begin
            if (r_emit_hold) begin
               r_emit_hold <= 1'b0;
               r_dl_offset <= r_zone_cnt;
            end else begin
               r_need_fetch <= (r_zone_cnt == 4'h0);
            end
         end

         if (w_frame_load) begin
            r_dll_addr   <= ZP;
            r_need_fetch <= 1'b1;
         end
      end
   end

   assign mem_req   = r_mem_req;
   assign mem_addr  = r_dll_addr;
   assign dl_valid  = (r_state == S_EMIT) && !r_emit_hold;
   assign dl_ptr    = r_dl_ptr;
   assign dl_offset = r_dl_offset;
   assign holey     = r_holey;
   assign dli       = r_dli;
   assign busy      = (r_state != S_IDLE);
   assign late      = line_start && (r_state != S_IDLE);

endmodule
